// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller for the 8 x 16-bit RAM_8 macro: one beat per cycle,
// address wraps modulo 8, read data returned through a one-entry backpressured register.
module ram_burst_ctrl #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_WR,
    input  logic [AW-1:0]    REQ_ADDR,
    input  logic [2:0]       REQ_LEN,
    input  logic             WDATA_VALID,
    output logic             WDATA_READY,
    input  logic [WIDTH-1:0] WDATA,
    output logic             RDATA_VALID,
    input  logic             RDATA_READY,
    output logic [WIDTH-1:0] RDATA,
    output logic             RDATA_LAST,
    output logic             BUSY,
    output logic [WIDTH-1:0] MEM_D,
    output logic             MEM_W,
    output logic             MEM_R,
    output logic             MEM_E,
    output logic [AW-1:0]    MEM_ADDR,
    input  logic [WIDTH-1:0] MEM_OUT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    logic [1:0]       state_q,       state_d;
    logic [AW-1:0]    cur_addr_q,    cur_addr_d;
    logic [2:0]       remaining_q,   remaining_d;
    logic [WIDTH-1:0] mem_d_q,       mem_d_d;
    logic             mem_w_q,       mem_w_d;
    logic             mem_r_q,       mem_r_d;
    logic [AW-1:0]    mem_addr_q,    mem_addr_d;
    logic [WIDTH-1:0] rdata_q,       rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             rdata_last_q,  rdata_last_d;

    logic req_hs;
    logic wdata_hs;
    logic capture;

    // REQ_READY is gated by RST_N so every output reads 0 while reset is held.
    assign REQ_READY   = RST_N && (state_q == S_IDLE) && !rdata_valid_q;
    assign WDATA_READY = (state_q == S_WR);
    assign req_hs      = REQ_VALID && REQ_READY;
    assign wdata_hs    = WDATA_VALID && WDATA_READY;
    assign capture     = !rdata_valid_q || RDATA_READY;

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        mem_d_d       = mem_d_q;
        mem_w_d       = 1'b0;
        mem_r_d       = mem_r_q;
        mem_addr_d    = mem_addr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        rdata_last_d  = rdata_last_q;

        if (rdata_valid_q && RDATA_READY) begin
            rdata_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                mem_r_d = 1'b0;
                if (req_hs) begin
                    cur_addr_d  = REQ_ADDR;
                    remaining_d = REQ_LEN;
                    if (REQ_WR) begin
                        state_d = S_WR;
                    end else begin
                        state_d    = S_RD;
                        mem_r_d    = 1'b1;
                        mem_addr_d = REQ_ADDR;
                    end
                end
            end
            S_WR: begin
                if (wdata_hs) begin
                    mem_d_d     = WDATA;
                    mem_addr_d  = cur_addr_q;
                    mem_w_d     = 1'b1;
                    cur_addr_d  = cur_addr_q + AW'(1);
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd0) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD: begin
                // The RAM read is combinational, so MEM_OUT already reflects MEM_ADDR here.
                if (capture) begin
                    rdata_d       = MEM_OUT;
                    rdata_valid_d = 1'b1;
                    rdata_last_d  = (remaining_q == 3'd0);
                    cur_addr_d    = cur_addr_q + AW'(1);
                    mem_addr_d    = cur_addr_q + AW'(1);
                    remaining_d   = remaining_q - 3'd1;
                    if (remaining_q == 3'd0) begin
                        mem_r_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                mem_r_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; all next-state logic lives in always_comb.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            mem_d_q       <= '0;
            mem_w_q       <= 1'b0;
            mem_r_q       <= 1'b0;
            mem_addr_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            mem_d_q       <= mem_d_d;
            mem_w_q       <= mem_w_d;
            mem_r_q       <= mem_r_d;
            mem_addr_q    <= mem_addr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    assign BUSY        = (state_q != S_IDLE);
    assign MEM_D       = mem_d_q;
    assign MEM_W       = mem_w_q;
    assign MEM_R       = mem_r_q;
    assign MEM_E       = mem_w_q | mem_r_q;
    assign MEM_ADDR    = mem_addr_q;
    assign RDATA       = rdata_q;
    assign RDATA_VALID = rdata_valid_q;
    assign RDATA_LAST  = rdata_last_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl with a behavioural RAM_8 (sync write, combinational read)
// and a scoreboard of expected read beats built from a shadow copy of memory.
module tb_ram_burst_ctrl;

    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             REQ_VALID = 1'b0;
    logic             REQ_READY;
    logic             REQ_WR = 1'b0;
    logic [AW-1:0]    REQ_ADDR = '0;
    logic [2:0]       REQ_LEN = '0;
    logic             WDATA_VALID = 1'b0;
    logic             WDATA_READY;
    logic [WIDTH-1:0] WDATA = '0;
    logic             RDATA_VALID;
    logic             RDATA_READY = 1'b1;
    logic [WIDTH-1:0] RDATA;
    logic             RDATA_LAST;
    logic             BUSY;
    logic [WIDTH-1:0] MEM_D;
    logic             MEM_W;
    logic             MEM_R;
    logic             MEM_E;
    logic [AW-1:0]    MEM_ADDR;
    logic [WIDTH-1:0] MEM_OUT;

    ram_burst_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .WDATA_VALID(WDATA_VALID), .WDATA_READY(WDATA_READY), .WDATA(WDATA),
        .RDATA_VALID(RDATA_VALID), .RDATA_READY(RDATA_READY), .RDATA(RDATA),
        .RDATA_LAST(RDATA_LAST), .BUSY(BUSY),
        .MEM_D(MEM_D), .MEM_W(MEM_W), .MEM_R(MEM_R), .MEM_E(MEM_E),
        .MEM_ADDR(MEM_ADDR), .MEM_OUT(MEM_OUT)
    );

    always #5 CLK = ~CLK;

    // RAM_8 model: write on the rising edge, read combinationally; not cleared by reset.
    logic [WIDTH-1:0] ram [8] = '{default: '0};
    always @(posedge CLK) if (MEM_E && MEM_W) ram[MEM_ADDR] <= MEM_D;
    assign MEM_OUT = ram[MEM_ADDR];

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] model [8];
    logic             w_hist[$];
    logic [AW-1:0]    a_hist[$];
    int               tests = 0;
    int               fails = 0;

    wire [42:0] all_out = {REQ_READY, WDATA_READY, RDATA_VALID, RDATA, RDATA_LAST, BUSY,
                           MEM_D, MEM_W, MEM_R, MEM_E, MEM_ADDR};

    function automatic void w_stats(output int cnt, output int first, output int last);
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < w_hist.size(); i++) begin
            if (w_hist[i]) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
    endfunction

    task automatic do_req(input logic wr, input logic [2:0] addr, input logic [2:0] len);
        int waited;
        waited = 0;
        REQ_VALID = 1'b1; REQ_WR = wr; REQ_ADDR = addr; REQ_LEN = len;
        @(negedge CLK);
        while (!REQ_READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        tests++;
        if (REQ_READY !== 1'b1) begin
            fails++;
            $display("FAIL req_accept: REQ_READY=%b required 1 within 50 cycles", REQ_READY);
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic write_burst(input logic [2:0] addr, input int n, input logic [WIDTH-1:0] data [8],
                               input int stall_after, input int stall_cyc);
        int beat, stalled, cyc;
        logic hs;
        beat = 0; stalled = 0; cyc = 0;
        w_hist.delete(); a_hist.delete();
        do_req(1'b1, addr, 3'(n - 1));
        while (beat < n && cyc < 100) begin
            if (beat == stall_after && stalled < stall_cyc) begin
                WDATA_VALID = 1'b0;
                stalled++;
            end else begin
                WDATA_VALID = 1'b1;
                WDATA = data[beat];
            end
            @(negedge CLK);
            w_hist.push_back(MEM_W); a_hist.push_back(MEM_ADDR);
            hs = WDATA_VALID && WDATA_READY;
            @(posedge CLK); #1;
            if (hs) begin
                model[3'(addr + beat)] = data[beat];
                beat++;
            end
            cyc++;
        end
        WDATA_VALID = 1'b0;
        tests++;
        if (beat != n) begin
            fails++;
            $display("FAIL wr_beats: accepted %0d required %0d", beat, n);
        end
        repeat (3) begin
            @(negedge CLK);
            w_hist.push_back(MEM_W); a_hist.push_back(MEM_ADDR);
        end
        @(posedge CLK); #1;
    endtask

    task automatic read_burst(input logic [2:0] addr, input int n, input int bp_beat, input int bp_cyc);
        int got, held, cyc, lat;
        logic [AW-1:0] hold_addr;
        beat_t b;
        for (int i = 0; i < n; i++) exp_q.push_back({model[3'(addr + i)], (i == n - 1)});
        do_req(1'b0, addr, 3'(n - 1));
        got = 0; held = 0; cyc = 0; lat = -1; hold_addr = '0;
        while (got < n && cyc < 200) begin
            RDATA_READY = !(got == bp_beat && held < bp_cyc);
            @(negedge CLK);
            if (RDATA_VALID && lat < 0) lat = cyc;
            if (!RDATA_READY) begin
                tests++;
                if (exp_q.size() == 0 || RDATA !== exp_q[0].data) begin
                    fails++;
                    $display("FAIL bp_hold_data: RDATA=%h required held beat", RDATA);
                end
                if (held == 0) hold_addr = MEM_ADDR;
                else begin
                    tests++;
                    if (MEM_ADDR !== hold_addr) begin
                        fails++;
                        $display("FAIL bp_hold_addr: MEM_ADDR=%0d required %0d", MEM_ADDR, hold_addr);
                    end
                end
                held++;
            end else if (RDATA_VALID) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_extra: unexpected beat RDATA=%h", RDATA);
                end else begin
                    b = exp_q.pop_front();
                    if (RDATA !== b.data || RDATA_LAST !== b.last) begin
                        fails++;
                        $display("FAIL rd_beat%0d: RDATA=%h LAST=%b required %h LAST=%b",
                                 got, RDATA, RDATA_LAST, b.data, b.last);
                    end
                end
                got++;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        RDATA_READY = 1'b1;
        tests++;
        if (got != n) begin
            fails++;
            $display("FAIL rd_beats: received %0d required %0d", got, n);
        end
        tests++;
        if (lat != 1) begin
            fails++;
            $display("FAIL rd_latency: first valid %0d cycles after accept required 1", lat);
        end
        @(negedge CLK);
        tests++;
        if (RDATA_VALID !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL rd_done: RDATA_VALID=%b BUSY=%b required 0 0", RDATA_VALID, BUSY);
        end
        @(posedge CLK); #1;
        exp_q.delete();
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: outputs=%h required 0", all_out);
        end
        @(posedge CLK); #3; RST_N = 1'b1;
        @(negedge CLK);
        tests++;
        if (REQ_READY !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: REQ_READY=%b required 1", REQ_READY);
        end
        @(posedge CLK); #1;
        RDATA_READY = 1'b0;
        do_req(1'b0, 3'd0, 3'd7);
        @(posedge CLK); #1;
        tests++;
        if (BUSY !== 1'b1 || RDATA_VALID !== 1'b1 || MEM_R !== 1'b1) begin
            fails++;
            $display("FAIL busy_before_reset: BUSY=%b RDATA_VALID=%b MEM_R=%b required 1 1 1",
                     BUSY, RDATA_VALID, MEM_R);
        end
        #2; RST_N = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_async: outputs=%h required 0 before any edge", all_out);
        end
        @(posedge CLK); #3; RST_N = 1'b1;
        RDATA_READY = 1'b1;
        @(negedge CLK);
        tests++;
        if (REQ_READY !== 1'b1) begin
            fails++;
            $display("FAIL reset_rerelease_ready: REQ_READY=%b required 1", REQ_READY);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_full_write_read;
        logic [WIDTH-1:0] d [8];
        int cnt, first, last;
        for (int i = 0; i < 8; i++) d[i] = WIDTH'(i + 1);
        write_burst(3'd0, 8, d, -1, 0);
        w_stats(cnt, first, last);
        tests++;
        if (cnt != 8 || last - first + 1 != 8) begin
            fails++;
            $display("FAIL full_mem_w: high %0d cycles span %0d required 8 consecutive", cnt, last - first + 1);
        end
        read_burst(3'd0, 8, -1, 0);
    endtask

    task automatic test_wrap;
        logic [WIDTH-1:0] d [8];
        logic [AW-1:0] exp_a [4];
        int k;
        d = '{default: '0};
        d[0] = 16'hA; d[1] = 16'hB; d[2] = 16'hC; d[3] = 16'hD;
        exp_a[0] = 3'd6; exp_a[1] = 3'd7; exp_a[2] = 3'd0; exp_a[3] = 3'd1;
        write_burst(3'd6, 4, d, -1, 0);
        k = 0;
        for (int i = 0; i < w_hist.size(); i++) begin
            if (w_hist[i]) begin
                tests++;
                if (k >= 4 || a_hist[i] !== exp_a[k]) begin
                    fails++;
                    $display("FAIL wrap_addr%0d: MEM_ADDR=%0d required %0d", k, a_hist[i], (k < 4) ? exp_a[k] : 3'd0);
                end
                k++;
            end
        end
        tests++;
        if (k != 4) begin
            fails++;
            $display("FAIL wrap_count: %0d writes required 4", k);
        end
        read_burst(3'd6, 4, -1, 0);
    endtask

    task automatic test_write_stall;
        logic [WIDTH-1:0] d [8];
        int cnt, first, last;
        d = '{default: '0};
        d[0] = 16'h0011; d[1] = 16'h0022; d[2] = 16'h0033; d[3] = 16'h0044;
        write_burst(3'd2, 4, d, 1, 2);
        w_stats(cnt, first, last);
        tests++;
        if (cnt != 4 || w_hist[1] !== 1'b1 || w_hist[2] !== 1'b0 || w_hist[3] !== 1'b0 || w_hist[4] !== 1'b1) begin
            fails++;
            $display("FAIL stall_mem_w: count=%0d pattern=%b%b%b%b required 4 and 1001",
                     cnt, w_hist[1], w_hist[2], w_hist[3], w_hist[4]);
        end
        tests++;
        if (a_hist[2] !== 3'd2 || a_hist[3] !== 3'd2 || a_hist[4] !== 3'd3) begin
            fails++;
            $display("FAIL stall_addr: MEM_ADDR=%0d,%0d,%0d required 2,2,3", a_hist[2], a_hist[3], a_hist[4]);
        end
        read_burst(3'd2, 4, -1, 0);
    endtask

    task automatic test_read_backpressure;
        logic [WIDTH-1:0] d [8];
        for (int i = 0; i < 8; i++) d[i] = WIDTH'(i + 1);
        write_burst(3'd0, 8, d, -1, 0);
        read_burst(3'd0, 8, 3, 3);
    endtask

    task automatic test_reset_mid_write;
        logic [WIDTH-1:0] d [8];
        d = '{default: 16'h00FF};
        write_burst(3'd0, 4, d, -1, 0);
        do_req(1'b1, 3'd0, 3'd3);
        WDATA_VALID = 1'b1; WDATA = 16'd1;
        @(posedge CLK); #1; WDATA = 16'd2;
        @(posedge CLK); #1; WDATA = 16'd3;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        WDATA_VALID = 1'b0;
        #1;
        tests++;
        if (MEM_W !== 1'b0 || MEM_E !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_mem_w: MEM_W=%b MEM_E=%b required 0 0", MEM_W, MEM_E);
        end
        @(posedge CLK); #3; RST_N = 1'b1;
        @(posedge CLK); #1;
        model[0] = 16'd1;
        model[1] = 16'd2;
        read_burst(3'd0, 4, -1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) model[i] = '0;
        test_reset();
        test_full_write_read();
        test_wrap();
        test_write_stall();
        test_read_backpressure();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Initiator-side controller for the 8 × 16-bit `RAM_8` memory. It sits between a processor-side request port and the RAM's `D/W/R/E/ADDR/OUT` pins. It accepts single or burst (1–8 beat) read/write requests over valid/ready handshakes and sequences the RAM strobes at one beat per cycle, wrapping the address modulo 8. Read data is returned through a one-entry output register that honours backpressure.

## Interface
- `WIDTH`, 16, data width (matches RAM word)
- `AW`, 3, address width (8 words)
- `CLK`  in  1  clock; all state changes on rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `REQ_VALID`  in  1  request present
- `REQ_READY`  out  1  request accepted on the edge where `REQ_VALID` and `REQ_READY` are both high
- `REQ_WR`  in  1  1 = write burst, 0 = read burst
- `REQ_ADDR`  in  AW  start address
- `REQ_LEN`  in  3  beats minus 1 (0..7)
- `WDATA_VALID`  in  1  write beat present
- `WDATA_READY`  out  1  write beat accepted on handshake
- `WDATA`  in  WIDTH  write beat data
- `RDATA_VALID`  out  1  read beat held
- `RDATA_READY`  in  1  consumer takes beat
- `RDATA`  out  WIDTH  read beat data
- `RDATA_LAST`  out  1  final beat of the burst
- `BUSY`  out  1  state ≠ IDLE
- `MEM_D`  out  WIDTH  to RAM `D`
- `MEM_W`  out  1  to RAM `W`
- `MEM_R`  out  1  to RAM `R`
- `MEM_E`  out  1  to RAM `E`; equals `MEM_W | MEM_R`
- `MEM_ADDR`  out  AW  to RAM `ADDR`
- `MEM_OUT`  in  WIDTH  from RAM `OUT`

## Operation
- FSM states: IDLE, WR, RD.
- IDLE:
  - `REQ_READY = !RDATA_VALID`.
  - On a request handshake, latch the start address into `cur_addr` and `REQ_LEN` into `remaining`.
  - `REQ_WR = 1` goes to WR; `REQ_WR = 0` goes to RD.
- WR:
  - `WDATA_READY = 1`.
  - On each beat handshake, register `MEM_D = WDATA`, `MEM_ADDR = cur_addr`, `MEM_W = 1`.
  - `cur_addr` increments modulo 8 (7 → 0). `remaining` decrements.
  - The beat accepted with `remaining == 0` returns the FSM to IDLE.
  - A cycle with no beat handshake registers `MEM_W = 0` and holds the address (stall, no write).
- RD:
  - Registered `MEM_R = 1` and `MEM_ADDR = cur_addr` from the accept edge onward.
  - Capture condition: `!RDATA_VALID || RDATA_READY`. When it holds at an edge:
    - `RDATA = MEM_OUT`, `RDATA_VALID = 1`, `RDATA_LAST = (remaining == 0)`.
    - Address advances modulo 8 and `remaining` decrements.
  - When the capture condition is false, address, `MEM_R` and the output register hold (backpressure).
  - After the last capture, `MEM_R = 0` and the FSM goes to IDLE. `RDATA_VALID` clears when the last beat is taken.
- `REQ_VALID` outside IDLE is ignored (no handshake). `WDATA_VALID` outside WR is ignored.
- `MEM_W` and `MEM_R` are never high together.

## Timing
- RAM write timing:
  - The RAM samples `MEM_W/MEM_D/MEM_ADDR` on the rising edge after the controller registers them.
  - A write beat accepted at edge k is written into the RAM at edge k+1.
  - Continuous beats give 1 write per cycle.
- Read latency:
  - Request accepted at edge 0. `MEM_R` is high during cycle 0→1.
  - Beat 0 is captured and `RDATA_VALID` rises at edge 1. Subsequent beats follow 1 per cycle with no backpressure.
  - An N-beat read occupies the RAM for N cycles.
- After the last write beat, the FSM is IDLE one cycle while `MEM_W` is still high (RAM completing that beat). A new request may be accepted in that cycle.
- Reset (`RST_N` low, asynchronous): all outputs 0, state IDLE, `cur_addr` 0, `remaining` 0.
- Reset mid-burst:
  - `MEM_W/MEM_R` drop immediately, so no write occurs at the next edge.
  - Beats already written stay in the RAM. The pending `RDATA` beat is discarded.

## Test plan
- Reset: assert `RST_N = 0` mid-cycle → every output is 0 without waiting for `CLK`. `REQ_READY = 1` on the first cycle after release.
- Full write then read:
  - Stimulus: write addr 0, len 7, data 1..8 back-to-back; then read addr 0, len 7 with `RDATA_READY = 1`.
  - Required: `MEM_W` high exactly 8 consecutive cycles.
  - Required: `RDATA` = 1..8 on 8 consecutive cycles, first valid one cycle after accept, `RDATA_LAST` only on value 8.
- Wrap: write addr 6, len 3, data 0xA,0xB,0xC,0xD → `MEM_ADDR` = 6,7,0,1. Read addr 6, len 3 returns 0xA..0xD.
- Write stall: 4-beat write with `WDATA_VALID` low for 2 cycles after beat 1 → `MEM_W` low for those 2 cycles, `MEM_ADDR` held, readback correct.
- Read backpressure: 8-beat read with `RDATA_READY` low for 3 cycles at beat 3 → `RDATA` holds beat 3 stable, `MEM_ADDR` holds. Full sequence 1..8 is delivered with no loss or duplication.
- Reset mid-write:
  - Preload addr 0..3 with 0xFF via a write burst.
  - Start a 4-beat write at addr 0 (data 1..4); assert `RST_N = 0` after beat 2 is written.
  - Required: readback gives 1, 2, 0xFF, 0xFF. `MEM_W` is 0 during reset.
